// File: rtl/sd_data_fifo_pkg.sv
// Shared SD data-path definitions: default widths/depths and FIFO operation decode.
// No logic of its own; imported by sd_data_fifo, sd_fifo_ram and the benches.
// Build option used by the FIFO files: SD_DATA_FIFO_FWFT_EN (first-word-fall-through read side).
package sd_data_fifo_pkg;

    localparam int SD_DATA_W      = 32;
    localparam int SD_DEPTH_LOG2  = 8;
    localparam int SD_BLOCK_WORDS = 128;

    // Encoding is {write accepted, read accepted}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RD   = 2'b01,
        OP_WR   = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic wr_ok, input logic rd_ok);
        return fifo_op_e'({wr_ok, rd_ok});
    endfunction

endpackage

// File: rtl/sd_fifo_ram.sv
// Simple dual-port word store for the SD data FIFO: one synchronous write port, one read port.
// Latency: read is combinational with SD_DATA_FIFO_FWFT_EN, otherwise a registered read with enable.
// Backpressure: none; the caller only issues accepted reads/writes.
module sd_fifo_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Storage is deliberately not reset; the FIFO pointers define what is valid.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

`ifdef SD_DATA_FIFO_FWFT_EN
    assign rdata = mem_q[raddr];
`else
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

// File: rtl/sd_data_fifo.sv
// Host-to-dat_phys word FIFO with occupancy count, SD block-ready flag and sticky overflow/underflow.
// Latency: read data 1 cycle after accepted rd_en; 0 cycles when SD_DATA_FIFO_FWFT_EN is defined.
// Backpressure: writes dropped while full, reads ignored while empty; each sets its sticky error flag.
module sd_data_fifo
    import sd_data_fifo_pkg::*;
#(
    parameter int DATA_W      = SD_DATA_W,
    parameter int DEPTH_LOG2  = SD_DEPTH_LOG2,
    parameter int BLOCK_WORDS = SD_BLOCK_WORDS
) (
    input  logic                  sd_clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     dataFROMFIFO,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  block_ready,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT  = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0] BLOCK_CNT = (DEPTH_LOG2+1)'(BLOCK_WORDS);
    localparam logic [DEPTH_LOG2:0] CNT_ONE   = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic                  wr_ok, rd_ok;
    fifo_op_e              op;
    logic [DATA_W-1:0]     ram_rdata;

    assign empty       = (count_q == '0);
    assign full        = (count_q == FULL_CNT);
    assign block_ready = (count_q >= BLOCK_CNT);
    assign count       = count_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;

    // When full, a concurrent read still goes through; only the write is lost.
    assign wr_ok = wr_en & ~full;
    assign rd_ok = rd_en & ~empty;
    assign op    = fifo_op(wr_ok, rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q | (wr_en & full);
        unf_d    = unf_q | (rd_en & empty);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case (op)
                OP_WR: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    count_d  = count_q + CNT_ONE;
                end
                OP_RD: begin
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                    count_d  = count_q - CNT_ONE;
                end
                OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    rd_ptr_d = rd_ptr_q + PTR_ONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    sd_fifo_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (sd_clock),
        .rst   (reset),
        .we    (wr_ok & ~flush & ~reset),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .re    (rd_ok & ~flush),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

`ifdef SD_DATA_FIFO_FWFT_EN
    assign dataFROMFIFO = empty ? '0 : ram_rdata;
`else
    assign dataFROMFIFO = ram_rdata;
`endif

endmodule

// File: tb/tb_sd_data_fifo.sv
// Self-checking bench for sd_data_fifo (default, registered-read build).
// A reference queue model feeds an expected-data scoreboard that a negedge monitor drains.
module tb_sd_data_fifo;
    import sd_data_fifo_pkg::*;

    localparam int DW    = SD_DATA_W;
    localparam int DL    = SD_DEPTH_LOG2;
    localparam int DEPTH = 1 << DL;

    logic          sd_clock = 1'b0;
    logic          reset    = 1'b1;
    logic          flush    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          rd_en    = 1'b0;
    logic [DW-1:0] dataFROMFIFO;
    logic          full, empty, block_ready, overflow, underflow;
    logic [DL:0]   count;

    sd_data_fifo dut (
        .sd_clock     (sd_clock),
        .reset        (reset),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .dataFROMFIFO (dataFROMFIFO),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .block_ready  (block_ready),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 sd_clock = ~sd_clock;

    int            vecs = 0;
    int            errs = 0;
    logic [DW-1:0] mdl[$];
    logic [DW-1:0] exp_q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    bit            started = 1'b0;
    bit            saw_dead = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference model: updates on the same edge the DUT samples its inputs.
    always @(posedge sd_clock) begin : model
        int sz;
        sz = mdl.size();
        if (reset) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            exp_q.push_back('0);
            started = 1'b1;
        end else if (flush) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (wr_en && sz == DEPTH) m_ovf = 1'b1;
            if (rd_en && sz == 0)     m_unf = 1'b1;
            if (rd_en && sz != 0)     exp_q.push_back(mdl.pop_front());
            if (wr_en && sz != DEPTH) mdl.push_back(wr_data);
        end
    end

    always @(negedge sd_clock) begin : monitor
        logic [DW-1:0] e;
        if (started) begin
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", dataFROMFIFO, e);
                if (dataFROMFIFO == 32'hDEADBEEF) saw_dead = 1'b1;
            end
            chk("sb_flags", {count, empty, full, block_ready, overflow, underflow},
                {(DL+1)'(mdl.size()), (mdl.size() == 0), (mdl.size() == DEPTH),
                 (mdl.size() >= SD_BLOCK_WORDS), m_ovf, m_unf});
        end
    end

    task automatic tick();
        @(posedge sd_clock);
        #1;
    endtask

    task automatic wr(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic rd();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_block", block_ready, 0);
        chk("rst_data", dataFROMFIFO, 0);

        // Three words in, three out, one-cycle read latency.
        for (int i = 1; i <= 3; i++) wr(DW'(i));
        for (int i = 1; i <= 3; i++) begin
            rd();
            chk("t1_pop", dataFROMFIFO, i);
        end
        chk("t1_count", count, 0);
        chk("t1_empty", empty, 1);

        // block_ready threshold.
        for (int i = 0; i < 128; i++) begin
            wr(32'h100 + DW'(i));
            if (i == 126) chk("t2_block_127", block_ready, 0);
        end
        chk("t2_block_128", block_ready, 1);
        chk("t2_count", count, 128);
        rd();
        chk("t2_block_fall", block_ready, 0);
        chk("t2_pop", dataFROMFIFO, 32'h100);
        repeat (127) rd();
        chk("t2_last", dataFROMFIFO, 32'h17F);

        // Fill, overflow, read-wins-when-full, drain.
        for (int i = 0; i < 256; i++) wr(32'h1000 + DW'(i));
        chk("t3_full", full, 1);
        chk("t3_count", count, 256);
        wr(32'hDEADBEEF);
        chk("t3_ovf", overflow, 1);
        chk("t3_count_ovf", count, 256);
        wr_en = 1'b1; wr_data = 32'hDEADBEEF; rd_en = 1'b1;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t3_both_full_cnt", count, 255);
        chk("t3_both_full_dat", dataFROMFIFO, 32'h1000);
        repeat (255) rd();
        chk("t3_last", dataFROMFIFO, 32'h10FF);
        tick();
        chk("t3_no_dead", saw_dead, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_flush_ovf", overflow, 0);

        // Simultaneous write+read at count 10.
        for (int i = 0; i < 10; i++) wr(32'h2000 + DW'(i));
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 32'h3000 + DW'(i); rd_en = 1'b1;
            tick();
            chk("t4_count", count, 10);
            chk("t4_pop", dataFROMFIFO, 32'h2000 + i);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        repeat (10) rd();
        chk("t4_last", dataFROMFIFO, 32'h3004);

        // 300 writes with every other cycle popping; pointers wrap.
        for (int i = 0; i < 300; i++) begin
            wr_en = 1'b1; wr_data = 32'h4000 + DW'(i); rd_en = (i % 2 == 1);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0;
        chk("t5_count", count, 150);
        chk("t5_mid", dataFROMFIFO, 32'h4095);
        repeat (150) rd();
        chk("t5_last", dataFROMFIFO, 32'h412B);

        // Underflow, flush priority over a write, then mid-block reset.
        rd();
        chk("t6_unf", underflow, 1);
        chk("t6_unf_hold", dataFROMFIFO, 32'h412B);
        flush = 1'b1; wr_en = 1'b1; wr_data = 32'h5555;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        chk("t6_flush_cnt", count, 0);
        chk("t6_flush_unf", underflow, 0);
        chk("t6_flush_hold", dataFROMFIFO, 32'h412B);
        for (int i = 0; i < 5; i++) wr(32'h6000 + DW'(i));
        rd();
        chk("t6_pre_rst", dataFROMFIFO, 32'h6000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_full", full, 0);
        chk("t6_rst_block", block_ready, 0);
        chk("t6_rst_data", dataFROMFIFO, 0);
        chk("t6_rst_flags", {overflow, underflow}, 0);

        repeat (2) tick();
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
